// File: rtl/mem_responder_if.sv
// Request/response bus between a control FSM (master) and the memory responder (slave).
interface mem_responder_if;
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] rdata;
    logic        err;
    logic        busy;

    modport master (output req, we, addr, wdata, input ack, rdata, err, busy);
    modport slave  (input req, we, addr, wdata, output ack, rdata, err, busy);
endinterface

// File: rtl/mem_responder.sv
// Single-port 16-bit memory responder with a fixed WAIT-cycle latency per transfer.
// Out-of-range addresses (>= DEPTH) complete normally but report err with zero read data.
module mem_responder #(
    parameter int unsigned DEPTH = 200,
    parameter int unsigned WAIT  = 2
) (
    input logic           clk,
    input logic           rst,
    mem_responder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAITING, RESP} state_t;

    localparam logic [3:0] CNT_INIT = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic        we_q;
    logic [7:0]  addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        err_q;

    logic        access;
    logic        acc_we;
    logic [7:0]  acc_addr;
    logic [15:0] acc_wdata;
    logic        in_range;

    logic [15:0] mem [DEPTH];

    // Zero-wait transfers access straight from the bus at the accepting edge
    always_comb begin
        acc_we    = (state == IDLE) ? bus.we    : we_q;
        acc_addr  = (state == IDLE) ? bus.addr  : addr_q;
        acc_wdata = (state == IDLE) ? bus.wdata : wdata_q;
        in_range  = 32'(acc_addr) < DEPTH;
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        access  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (WAIT == 0) begin
                        access  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WAITING;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAITING: begin
                if (cnt == 4'd0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (state == IDLE && bus.req) begin
                we_q    <= bus.we;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
            if (access) begin
                err_q <= !in_range;
                if (!in_range)
                    rdata_q <= '0;
                else if (!acc_we)
                    rdata_q <= mem[acc_addr];
            end
        end
    end

    // Memory has no reset; a reset edge suppresses any pending write
    always_ff @(posedge clk) begin
        if (!rst && access && acc_we && in_range)
            mem[acc_addr] <= acc_wdata;
    end

    always_comb begin
        bus.ack   = (state == RESP);
        bus.busy  = (state != IDLE);
        bus.err   = (state == RESP) && err_q;
        bus.rdata = rdata_q;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: three responders (WAIT=2/0/3, DEPTH=200) against a countdown/array model.
module tb_mem_responder;

    localparam int unsigned DEPTH = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req_v = '0;
    logic [2:0]  we_v = '0;
    logic [7:0]  addr_v [3];
    logic [15:0] wdata_v [3];
    logic [2:0]  ack_v, err_v, busy_v;
    logic [15:0] rd_a [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_responder_if bus0 ();
    mem_responder_if bus1 ();
    mem_responder_if bus2 ();

    assign bus0.req = req_v[0];  assign bus0.we = we_v[0];
    assign bus0.addr = addr_v[0]; assign bus0.wdata = wdata_v[0];
    assign bus1.req = req_v[1];  assign bus1.we = we_v[1];
    assign bus1.addr = addr_v[1]; assign bus1.wdata = wdata_v[1];
    assign bus2.req = req_v[2];  assign bus2.we = we_v[2];
    assign bus2.addr = addr_v[2]; assign bus2.wdata = wdata_v[2];

    assign ack_v  = {bus2.ack,  bus1.ack,  bus0.ack};
    assign err_v  = {bus2.err,  bus1.err,  bus0.err};
    assign busy_v = {bus2.busy, bus1.busy, bus0.busy};
    assign rd_a[0] = bus0.rdata;
    assign rd_a[1] = bus1.rdata;
    assign rd_a[2] = bus2.rdata;

    mem_responder #(.DEPTH(DEPTH), .WAIT(2)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mem_responder #(.DEPTH(DEPTH), .WAIT(0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mem_responder #(.DEPTH(DEPTH), .WAIT(3)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // Model: per instance, cycles left until idle; ack is the last busy cycle
    int          waits [3] = '{2, 0, 3};
    bit          armed = 1'b0;
    int          m_left [3];
    logic        t_we [3];
    logic [7:0]  t_addr [3];
    logic [15:0] t_wd [3];
    logic [15:0] e_rd [3];
    bit          e_known [3];
    bit          e_err [3];
    logic [15:0] mmem [3][256];
    bit          mwr [3][256];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_access(input int k);
        if (32'(t_addr[k]) >= DEPTH) begin
            e_rd[k] = '0; e_known[k] = 1'b1; e_err[k] = 1'b1;
        end else begin
            e_err[k] = 1'b0;
            if (t_we[k]) begin
                mmem[k][t_addr[k]] = t_wd[k];
                mwr[k][t_addr[k]]  = 1'b1;
            end else begin
                e_rd[k]    = mmem[k][t_addr[k]];
                e_known[k] = mwr[k][t_addr[k]];
            end
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_left[k] = 0; e_rd[k] = '0; e_known[k] = 1'b1; e_err[k] = 1'b0;
            end else if (m_left[k] == 0) begin
                if (req_v[k]) begin
                    t_we[k] = we_v[k]; t_addr[k] = addr_v[k]; t_wd[k] = wdata_v[k];
                    m_left[k] = waits[k] + 1;
                    if (m_left[k] == 1) m_access(k);
                end
            end else begin
                m_left[k]--;
                if (m_left[k] == 1) m_access(k);
            end
        end
        if (rst) armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("ack%0d", k),  32'(ack_v[k]),  32'(m_left[k] == 1));
                chk($sformatf("busy%0d", k), 32'(busy_v[k]), 32'(m_left[k] > 0));
                chk($sformatf("err%0d", k),  32'(err_v[k]),  32'(m_left[k] == 1 && e_err[k]));
                if (e_known[k])
                    chk($sformatf("rdata%0d", k), 32'(rd_a[k]), 32'(e_rd[k]));
            end
        end
    end

    // Caller is at a negedge; req is held for exactly one edge
    task automatic xact(input int k, input logic w, input logic [7:0] a, input logic [15:0] d,
                        output int lat, output int bsy, output logic [15:0] rd, output logic er);
        req_v[k] = 1'b1; we_v[k] = w; addr_v[k] = a; wdata_v[k] = d;
        lat = 0; bsy = 0; rd = '0; er = 1'b0;
        @(negedge clk);
        req_v[k] = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (busy_v[k]) bsy++;
            if (ack_v[k]) begin
                lat = i; rd = rd_a[k]; er = err_v[k];
                break;
            end
            @(negedge clk);
        end
        chk("ack_seen", 32'(lat != 0), 32'd1);
        @(negedge clk);
    endtask

    int          lat, bsy, acks;
    logic [15:0] rd;
    logic        er;

    initial begin
        for (int k = 0; k < 3; k++) begin
            addr_v[k] = '0; wdata_v[k] = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack_v), 32'd0);
        chk("rst_busy", 32'(busy_v), 32'd0);
        chk("rst_err", 32'(err_v), 32'd0);
        chk("rst_rdata", 32'(rd_a[0]), 32'd0);
        rst = 1'b0;

        // Reset interrupting a write; req right after reset release
        xact(0, 1'b1, 8'h20, 16'h0001, lat, bsy, rd, er);
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 8'h20; wdata_v[0] = 16'hDEAD;
        @(negedge clk);
        req_v[0] = 1'b0;
        chk("pre_rst_busy", 32'(busy_v[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy_v[0]), 32'd0);
        chk("post_rst_ack", 32'(ack_v[0]), 32'd0);
        rst = 1'b0;
        xact(0, 1'b0, 8'h20, 16'h0000, lat, bsy, rd, er);
        chk("rst_write_lost", 32'(rd), 32'h0001);

        // Write then read, WAIT=2
        xact(0, 1'b1, 8'h10, 16'hBEEF, lat, bsy, rd, er);
        chk("w_latency", 32'(lat), 32'd3);
        chk("w_busy_cycles", 32'(bsy), 32'd3);
        xact(0, 1'b0, 8'h10, 16'h0000, lat, bsy, rd, er);
        chk("r_rdata", 32'(rd), 32'hBEEF);
        chk("r_err", 32'(er), 32'd0);

        // Out-of-range accesses
        xact(0, 1'b1, 8'h48, 16'h5A5A, lat, bsy, rd, er);
        xact(0, 1'b1, 8'hC8, 16'h1234, lat, bsy, rd, er);
        chk("oor_w_err", 32'(er), 32'd1);
        chk("oor_w_rdata", 32'(rd), 32'd0);
        xact(0, 1'b0, 8'hC8, 16'h0000, lat, bsy, rd, er);
        chk("oor_r_err", 32'(er), 32'd1);
        chk("oor_r_rdata", 32'(rd), 32'd0);
        xact(0, 1'b0, 8'h48, 16'h0000, lat, bsy, rd, er);
        chk("oor_neighbour", 32'(rd), 32'h5A5A);
        xact(0, 1'b0, 8'hC7, 16'h0000, lat, bsy, rd, er);
        chk("last_word_err", 32'(er), 32'd0);

        // New inputs while busy are ignored
        req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 8'h10;
        @(negedge clk);
        req_v[0] = 1'b0; we_v[0] = 1'b1; addr_v[0] = 8'h48; wdata_v[0] = 16'h0000;
        repeat (2) @(negedge clk);
        chk("latched_ack", 32'(ack_v[0]), 32'd1);
        chk("latched_rdata", 32'(rd_a[0]), 32'hBEEF);
        @(negedge clk);
        xact(0, 1'b0, 8'h48, 16'h0000, lat, bsy, rd, er);
        chk("latched_no_write", 32'(rd), 32'h5A5A);

        // Zero wait: single read, then req held high
        xact(1, 1'b1, 8'h05, 16'h0777, lat, bsy, rd, er);
        xact(1, 1'b0, 8'h05, 16'h0000, lat, bsy, rd, er);
        chk("w0_latency", 32'(lat), 32'd1);
        chk("w0_rdata", 32'(rd), 32'h0777);
        req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 8'h05;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack_v[1]) acks++;
        end
        req_v[1] = 1'b0;
        chk("w0_held_acks", 32'(acks), 32'd5);
        @(negedge clk);

        // Req dropped after one cycle, WAIT=3
        xact(2, 1'b1, 8'h30, 16'hCAFE, lat, bsy, rd, er);
        chk("w3_latency", 32'(lat), 32'd4);
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack_v[2]) acks++;
        end
        chk("w3_no_repeat", 32'(acks), 32'd0);

        // Random traffic on all three instances, model-checked every cycle
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(199) == 0);
            for (int k = 0; k < 3; k++) begin
                req_v[k] = ($urandom_range(2) != 0);
                we_v[k]  = 1'(($urandom));
                case ($urandom_range(2))
                    0:       addr_v[k] = 8'($urandom_range(15));
                    1:       addr_v[k] = 8'($urandom_range(203, 196));
                    default: addr_v[k] = 8'($urandom);
                endcase
                wdata_v[k] = 16'($urandom);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        req_v = '0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 200, giving the number of implemented 16-bit words (1..256).
REQ-002 The block SHALL have parameter WAIT, default 2, giving the wait cycles inserted before each response (0..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req, input, 1 bit: the initiator (control FSM) requests a transfer.
REQ-006 The block SHALL have port we, input, 1 bit: 1 means write, 0 means read; sampled with req.
REQ-007 The block SHALL have port addr, input, 8 bits: word address; sampled with req.
REQ-008 The block SHALL have port wdata, input, 16 bits: write data; sampled with req.
REQ-009 The block SHALL have port ack, output, 1 bit: one-cycle response strobe.
REQ-010 The block SHALL have port rdata, output, 16 bits: read data, valid while ack=1.
REQ-011 The block SHALL have port err, output, 1 bit: address-range error, valid while ack=1.
REQ-012 The block SHALL have port busy, output, 1 bit: a transaction is accepted and not yet acknowledged.

Function
REQ-013 The block SHALL implement the states IDLE, WAITING and RESP, with a 4-bit wait counter cnt.
REQ-014 In IDLE with req=1 at an edge, the block SHALL latch we, addr and wdata, and move to WAITING with cnt=WAIT-1; when WAIT=0 it SHALL instead perform the access at that edge and move to RESP.
REQ-015 In WAITING, the block SHALL decrement cnt on each edge while cnt>0.
REQ-016 In WAITING with cnt=0, the block SHALL perform the access at that edge and move to RESP.
REQ-017 Latency: with req sampled high at edge e0, ack SHALL be high for exactly the one cycle after edge e0+WAIT.
REQ-018 In RESP, the block SHALL drive ack=1 and move to IDLE at the next edge.
REQ-019 ack SHALL be a registered, state-decoded output with no combinational path from req.
REQ-020 busy SHALL be 1 in WAITING and RESP, and 0 in IDLE.
REQ-021 req, we, addr and wdata SHALL be ignored in WAITING and RESP; a transaction, once accepted, SHALL complete from latched values even if req drops.
REQ-022 A req still high in the RESP cycle SHALL NOT start a new transaction; it SHALL be accepted at the first edge in IDLE, so back-to-back transfers occur every WAIT+2 cycles.
REQ-023 Write access with latched addr<DEPTH: mem[addr] SHALL be set to wdata at the access edge, with rdata unchanged.
REQ-024 Read access with latched addr<DEPTH: rdata SHALL be registered from mem[addr] at the access edge.
REQ-025 A read SHALL return the value of any write completed in an earlier transaction.
REQ-026 Access with latched addr>=DEPTH SHALL leave memory unmodified, set rdata=16'h0000 and set err=1, for both reads and writes.
REQ-027 err SHALL be 0 whenever ack=0 and for in-range accesses.
REQ-028 rdata SHALL hold its last value outside ack cycles.
REQ-029 The memory array SHALL be uninitialised; a read of a never-written in-range location is a don't-care for verification.

Reset
REQ-030 When rst=1 at an edge, the block SHALL force state=IDLE, cnt=0, ack=0, err=0, busy=0 and rdata=16'h0000, overriding any in-flight transaction.
REQ-031 Reset SHALL NOT clear or modify memory contents.
REQ-032 A write interrupted by reset before its access edge SHALL NOT modify memory.
REQ-033 A req high in the first edge after rst falls SHALL be accepted normally.

Verification
REQ-034 The bench SHALL cover a write then a read (WAIT=2): write addr=8'h10, wdata=16'hBEEF -> ack in cycle e0+3, busy high for 3 cycles; read addr=8'h10 -> ack with rdata=16'hBEEF and err=0.
REQ-035 The bench SHALL cover the zero-wait case (WAIT=0): read -> ack in the cycle right after the accepting edge; with req held high, ack occurs every 2nd cycle.
REQ-036 The bench SHALL cover out-of-range accesses: write addr=8'hC8 (=DEPTH) with wdata=16'h1234 -> ack with err=1 and rdata=0; a later read of 8'hC8 -> err=1 and rdata=0; contents of addr 8'h48 unchanged.
REQ-037 The bench SHALL cover req dropping mid-transaction: req high for 1 cycle only, WAIT=3 -> ack still occurs at e0+4, and no second transaction follows.
REQ-038 The bench SHALL cover reset mid-operation: write to addr=8'h20 (prior value 16'h0001), rst asserted in WAITING -> no ack, busy=0 next cycle, and a later read of 8'h20 returns 16'h0001.
REQ-039 The bench SHALL cover new inputs during WAITING: change addr and we while busy=1 -> the response reflects only the originally latched request.
